// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP controller: IR decode, BYPASS and scan-chain strobes.
// Define JTAG_TAP_IDCODE_EN to add a 32-bit IDCODE register on instruction 8'h3E.
module jtag_tap_responder #(
    parameter int unsigned NUM_CHAINS   = 16,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                  tck,
    input  logic                  trstb,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdob,
    input  logic [NUM_CHAINS-1:0] chain_so,
    output logic [3:0]            chain_sel,
    output logic                  rd_en,
    output logic                  wrt_en,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic [3:0]            tap_state
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [7:0] IR_RESET    = 8'h3E;
    localparam logic [7:0] IDCODE_INSN = 8'h3E;
`else
    localparam logic [7:0] IR_RESET    = 8'hFF;
`endif

    tap_state_e state_q;
    tap_state_e state_d;
    logic [7:0] ir_q;
    logic [7:0] ir_shift_q;
    logic       bypass_q;
    logic       chain_hit;
    logic       idcode_hit;
    logic       chain_bit;

    always_ff @(posedge tck) begin
        if (!trstb) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // TLR holds the IR at its reset instruction, same as trstb.
    always_ff @(posedge tck) begin
        if (!trstb || state_q == TLR) begin
            ir_q <= IR_RESET;
        end else if (state_q == UPD_IR) begin
            ir_q <= ir_shift_q;
        end
    end

    always_ff @(posedge tck) begin
        if (!trstb) begin
            ir_shift_q <= 8'h00;
        end else if (state_q == CAP_IR) begin
            ir_shift_q <= 8'b0000_0001;
        end else if (state_q == SH_IR) begin
            ir_shift_q <= {tdi, ir_shift_q[7:1]};
        end
    end

    always_ff @(posedge tck) begin
        if (!trstb) begin
            bypass_q <= 1'b0;
        end else if (state_q == CAP_DR) begin
            bypass_q <= 1'b0;
        end else if (state_q == SH_DR) begin
            bypass_q <= tdi;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_q;

    always_ff @(posedge tck) begin
        if (!trstb) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state_q == CAP_DR) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state_q == SH_DR) begin
            idcode_q <= {tdi, idcode_q[31:1]};
        end
    end

    assign idcode_hit = (ir_q == IDCODE_INSN);
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
    assign idcode_hit    = 1'b0;
`endif

    assign chain_hit = (ir_q[5:4] == 2'b00) &&
                       (32'(ir_q[3:0]) < NUM_CHAINS);

    always_comb begin
        chain_bit = 1'b0;
        for (int i = 0; i < int'(NUM_CHAINS) && i < 16; i++) begin
            if (ir_q[3:0] == 4'(i)) begin
                chain_bit = chain_so[i];
            end
        end
    end

    // Inverted serial out; idles high outside the shift states.
    always_comb begin
        tdob = 1'b1;
        unique case (1'b1)
            state_q == SH_IR:
                tdob = ~ir_shift_q[0];
            state_q == SH_DR && chain_hit:
                tdob = ~chain_bit;
`ifdef JTAG_TAP_IDCODE_EN
            state_q == SH_DR && idcode_hit:
                tdob = ~idcode_q[0];
`endif
            state_q == SH_DR && !chain_hit && !idcode_hit:
                tdob = ~bypass_q;
            default:
                tdob = 1'b1;
        endcase
    end

    assign capture_dr = (state_q == CAP_DR) && chain_hit;
    assign shift_dr   = (state_q == SH_DR) && chain_hit;
    assign update_dr  = (state_q == UPD_DR) && chain_hit;

    assign rd_en     = ir_q[7];
    assign wrt_en    = ir_q[6];
    assign chain_sel = ir_q[3:0];
    assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: directed TAP sequences plus random tms/tdi,
// checked per cycle against a queue-based reference model.
module tb_jtag_tap_responder;

    localparam int          NC  = 16;
    localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [7:0]  RST = 8'h3E;
`else
    localparam logic [7:0]  RST = 8'hFF;
`endif

    localparam int TLR = 15, RTI = 12, SDR = 7, CDR = 6, SHDR = 2;
    localparam int E1DR = 1, PDR = 3, E2DR = 0, UDR = 5, SIR = 4;
    localparam int CIR = 14, SHIR = 10, E1IR = 9, PIR = 11;
    localparam int E2IR = 8, UIR = 13;

    logic          tck = 1'b0;
    logic          trstb;
    logic          tms;
    logic          tdi;
    logic          tdob;
    logic [NC-1:0] chain_so;
    logic [3:0]    chain_sel;
    logic          rd_en;
    logic          wrt_en;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic [3:0]    tap_state;

    jtag_tap_responder #(
        .NUM_CHAINS   (NC),
        .IDCODE_VALUE (IDV)
    ) dut (
        .tck        (tck),
        .trstb      (trstb),
        .tms        (tms),
        .tdi        (tdi),
        .tdob       (tdob),
        .chain_so   (chain_so),
        .chain_sel  (chain_sel),
        .rd_en      (rd_en),
        .wrt_en     (wrt_en),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tap_state  (tap_state)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [3:0] st;
        logic       tdob;
        logic [2:0] strb;
        logic [3:0] sel;
        logic       rd;
        logic       wrt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int         m_st;
    logic [7:0] m_ir;
    bit         m_irq[$];
    bit         m_dq[$];

    bit p30[5] = '{1, 0, 1, 1, 0};
    int t30[5] = '{0, 1, 0, 0, 1};
    bit d31[4] = '{1, 0, 1, 1};
    int t31[4] = '{1, 0, 1, 0};

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, expv, $time);
        end
    endfunction

    function automatic int nxt(int s, bit t);
        case (s)
            TLR:     return t ? TLR  : RTI;
            RTI:     return t ? SDR  : RTI;
            SDR:     return t ? SIR  : CDR;
            CDR:     return t ? E1DR : SHDR;
            SHDR:    return t ? E1DR : SHDR;
            E1DR:    return t ? UDR  : PDR;
            PDR:     return t ? E2DR : PDR;
            E2DR:    return t ? UDR  : SHDR;
            UDR:     return t ? SDR  : RTI;
            SIR:     return t ? TLR  : CIR;
            CIR:     return t ? E1IR : SHIR;
            SHIR:    return t ? E1IR : SHIR;
            E1IR:    return t ? UIR  : PIR;
            PIR:     return t ? E2IR : PIR;
            E2IR:    return t ? UIR  : SHIR;
            UIR:     return t ? SDR  : RTI;
            default: return TLR;
        endcase
    endfunction

    function automatic bit m_chain();
        return (m_ir[5:4] == 2'b00) && (int'(m_ir[3:0]) < NC);
    endfunction

    function automatic bit m_idc();
`ifdef JTAG_TAP_IDCODE_EN
        return m_ir == 8'h3E;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_step(bit rn, bit t, bit d);
        if (!rn) begin
            m_st = TLR;
            m_ir = RST;
            return;
        end
        case (m_st)
            TLR: m_ir = RST;
            CIR: begin
                m_irq.delete();
                m_irq.push_back(1'b1);
                repeat (7) m_irq.push_back(1'b0);
            end
            SHIR: if (m_irq.size() > 0) begin
                void'(m_irq.pop_front());
                m_irq.push_back(d);
            end
            UIR: for (int i = 0; i < 8; i++) m_ir[i] = m_irq[i];
            CDR: begin
                m_dq.delete();
                if (m_idc()) begin
                    for (int i = 0; i < 32; i++) m_dq.push_back(IDV[i]);
                end else begin
                    m_dq.push_back(1'b0);
                end
            end
            SHDR: if (!m_chain() && m_dq.size() > 0) begin
                void'(m_dq.pop_front());
                m_dq.push_back(d);
            end
            default: ;
        endcase
        m_st = nxt(m_st, t);
    endfunction

    function automatic logic [NC-1:0] rnd_so();
        return NC'($urandom);
    endfunction

    task automatic cycle(input bit t, input bit d, input logic [NC-1:0] so,
                         input bit rn, input int exp_tdob, input string nm);
        exp_t e;
        bit   ch;
        trstb    = rn;
        tms      = t;
        tdi      = d;
        chain_so = so;
        ch       = m_chain();
        e.st     = 4'(m_st);
        e.sel    = m_ir[3:0];
        e.rd     = m_ir[7];
        e.wrt    = m_ir[6];
        e.strb   = {ch && m_st == CDR, ch && m_st == SHDR, ch && m_st == UDR};
        e.tdob   = 1'b1;
        if (m_st == SHIR && m_irq.size() > 0) begin
            e.tdob = ~m_irq[0];
        end else if (m_st == SHDR) begin
            if (ch) e.tdob = ~so[m_ir[3:0]];
            else if (m_dq.size() > 0) e.tdob = ~m_dq[0];
        end
        exp_q.push_back(e);
        m_step(rn, t, d);
        if (exp_tdob >= 0) begin
            #2;
            chk(nm, 32'(tdob), 32'(exp_tdob));
        end
        @(posedge tck);
        #1;
    endtask

    task automatic step(input bit t);
        cycle(t, 1'($urandom), rnd_so(), 1'b1, -1, "");
    endtask

    task automatic tms_seq(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i]);
    endtask

    // From RTI: load v into the IR and return to RTI.
    task automatic shift_ir(input logic [7:0] v);
        tms_seq(32'b1100, 4);
        for (int i = 0; i < 8; i++) begin
            cycle(i == 7, v[i], rnd_so(), 1'b1, (i == 0) ? 0 : 1, "ir_tdob");
        end
        tms_seq(32'b10, 2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge tck);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tap_state", 32'(tap_state), 32'(e.st));
                chk("tdob", 32'(tdob), 32'(e.tdob));
                chk("strobes", 32'({capture_dr, shift_dr, update_dr}),
                    32'(e.strb));
                chk("chain_sel", 32'(chain_sel), 32'(e.sel));
                chk("rd_wrt", 32'({rd_en, wrt_en}), 32'({e.rd, e.wrt}));
            end
        end
    end

    initial begin : stimulus
        logic [NC-1:0] so;
        bit            prev;
        bit            d;
        int            exp_t33;
        trstb    = 1'b0;
        tms      = 1'b1;
        tdi      = 1'b0;
        chain_so = '0;
        @(posedge tck);
        #1;
        m_st = TLR;
        m_ir = RST;
        chk("reset_state", 32'(tap_state), 32'hF);
        chk("reset_tdob", 32'(tdob), 32'h1);
        chk("reset_sel", 32'(chain_sel), 32'(RST[3:0]));
        step(1'b0);

        shift_ir(8'hC5);
        chk("c5_rd_en", 32'(rd_en), 32'h1);
        chk("c5_wrt_en", 32'(wrt_en), 32'h1);
        chk("c5_chain_sel", 32'(chain_sel), 32'h5);

        tms_seq(32'b100, 3);
        for (int i = 0; i < 5; i++) begin
            so    = rnd_so();
            so[5] = p30[i];
            cycle(i == 4, 1'($urandom), so, 1'b1, t30[i], "chain5_tdob");
        end
        tms_seq(32'b10, 2);

        tms_seq(32'b1000, 4);
        cycle(1'b0, 1'($urandom), rnd_so(), 1'b0, -1, "");
        chk("rst_sh_state", 32'(tap_state), 32'hF);
        chk("rst_sh_upd", 32'(update_dr), 32'h0);
        chk("rst_sh_tdob", 32'(tdob), 32'h1);
        chk("rst_sh_sel", 32'(chain_sel), 32'(RST[3:0]));
        step(1'b0);

        shift_ir(8'hFF);
        tms_seq(32'b100, 3);
        for (int i = 0; i < 4; i++) begin
            cycle(i == 3, d31[i], rnd_so(), 1'b1, t31[i], "bypass_tdob");
        end
        tms_seq(32'b10, 2);

        tms_seq(32'b1010010101101101001010111110, 28);
        chk("walk_end", 32'(tap_state), 32'hC);

        cycle(1'b0, 1'b0, rnd_so(), 1'b0, -1, "");
        tms_seq(32'b0100, 4);
        prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            d = 1'($urandom);
`ifdef JTAG_TAP_IDCODE_EN
            exp_t33 = IDV[i] ? 0 : 1;
`else
            exp_t33 = (i == 0) ? 1 : (prev ? 0 : 1);
`endif
            cycle(i == 31, d, rnd_so(), 1'b1, exp_t33, "dr32_tdob");
            prev = d;
        end
        tms_seq(32'b10, 2);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 45, 1'($urandom), rnd_so(),
                  $urandom_range(0, 199) != 0, -1, "");
        end

        for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge tck);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_tap_responder.md
JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 Parameter NUM_CHAINS, 16, number of scan chains addressable by chainSelect.
REQ-002 Parameter IDCODE_VALUE, 32'h1000_0001, device ID captured when the IDCODE instruction is active.
REQ-003 tck  in  1  sole clock; all state changes on posedge tck.
REQ-004 trstb  in  1  reset; synchronous, active-low, sampled on posedge tck.
REQ-005 tms  in  1  TAP mode select.
REQ-006 tdi  in  1  serial data in.
REQ-007 tdob  out  1  complement of the selected serial-out bit; 1 when not shifting.
REQ-008 chain_so  in  NUM_CHAINS  serial-out (current LSB) of each scan chain.
REQ-009 chain_sel  out  4  chainSelect field of the current instruction.
REQ-010 rd_en, wrt_en  out  1 each  rdEn and wrtEn bits of the current instruction.
REQ-011 capture_dr, shift_dr, update_dr  out  1 each  level strobes to the selected chain, acted on at posedge tck.
REQ-012 tap_state  out  4  current TAP state code.

Function
REQ-013 The TAP FSM SHALL implement the 16 IEEE 1149.1 states and transitions, with codes TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
REQ-014 Five consecutive tms=1 posedges from any state SHALL reach TLR; TLR SHALL reset the IR exactly as trstb does.
REQ-015 The 8-bit IR shift register SHALL load 8'b0000_0001 on posedge in CapIR and shift LSB-first on each posedge in ShIR, including the exit posedge.
REQ-016 The current IR SHALL update from the shift register on posedge in UpdIR only.
REQ-017 IR decode: ir[7]=rdEn, ir[6]=wrtEn, ir[3:0]=chainSelect; a chain is selected only if ir[5:4]==2'b00 and ir[3:0]<NUM_CHAINS; otherwise BYPASS is selected.
REQ-018 The BYPASS register SHALL be 1 bit, load 0 in CapDR, and load tdi in ShDR.
REQ-019 capture_dr, shift_dr and update_dr SHALL each be high only in CapDR, ShDR and UpdDR respectively, and only when a chain is selected.
REQ-020 tdob SHALL be combinational: ~ir_shift[0] in ShIR; ~selected chain_so, ~bypass or ~idcode[0] in ShDR; 1 otherwise.
REQ-021 The first tdob bit in a shift SHALL be the captured LSB, valid before the first shift posedge; the bit driven on the exit posedge (tms=1) is also valid output.
REQ-022 rd_en, wrt_en and chain_sel SHALL change only on UpdIR, TLR or reset, never mid-shift.
REQ-023 Pause states SHALL hold all shift registers unchanged for any duration.

Reset
REQ-024 trstb=0 at posedge SHALL force tap_state=F and IR to its reset instruction (8'hFF, or 8'h3E with the macro), with all strobes 0 and tdob=1.
REQ-025 Reset mid-shift SHALL abandon the shift with no UpdDR/UpdIR strobe; trstb has no effect without a tck edge.

Configuration
REQ-026 Macro JTAG_TAP_IDCODE_EN defined: instruction 8'h3E SHALL select a 32-bit IDCODE register that captures IDCODE_VALUE in CapDR and shifts LSB-first; IR reset value 8'h3E.
REQ-027 Macro JTAG_TAP_IDCODE_EN undefined: no IDCODE register; 8'h3E decodes as BYPASS; IR reset value 8'hFF.

Verification
REQ-028 trstb=0 across one posedge from ShDR -> tap_state=F, no update_dr, tdob=1, chain_sel=4'hF.
REQ-029 From RTI, tms 1100, shift IR 8'hC5 LSB-first, exit via 110 -> tdob sequence 0,1,1,1,1,1,1,1 during shift; then rd_en=1, wrt_en=1, chain_sel=5.
REQ-030 With chain 5 selected, tms 100, 4 shift posedges plus exit, chain_so[5]=1,0,1,1,0 -> capture_dr high 1 cycle, shift_dr high 5 cycles, tdob 0,1,0,0,1, update_dr high 1 cycle.
REQ-031 IR 8'hFF, shift tdi 1,0,1,1 -> tdob 1,0,1,0 (captured 0, then one-cycle-delayed inverted tdi); no chain strobes.
REQ-032 tms 28'b1010010101101101001010111110 from RTI -> all 16 states visited, ends in RTI, strobes only in their own states.
REQ-033 After reset, shift 32 DR bits -> with macro tdob = ~IDCODE_VALUE LSB-first; without macro tdob 1 then ~tdi delayed (BYPASS).
